gsim_mtx_fetch: RTL and testbench
=================================

// Module: gsim_mtx_fetch
// PURPOSE
//  Parametrised matrix fetch engine for the Gauss-Seidel machine. Reads N+1 rows per matrix
//  (N rows of A, then b) from matrix memory via the rreq/rrdy/dout_vld handshake.
//  Buffers returned rows in a credit-protected FIFO and streams them, tagged, to the iteration datapath.
//  Supports all-matrices and single-matrix modes and multiple outstanding reads.
// PARAMETERS
//  MAT_DIM    16  matrix dimension N; rows per matrix ROWS = MAT_DIM+1 (row MAT_DIM = b vector)
//  ELEM_W     16  bits per element; row width DW = MAT_DIM*ELEM_W (256 at defaults)
//  ADDR_W     10  matrix memory address width
//  NUM_W       5  width of matrix count/index
//  FIFO_DEPTH  4  row buffer depth = max outstanding reads + buffered rows (power of 2, >=2)
// PORTS
//  i_clk          in   1       clock
//  i_rst_n        in   1       async active-low reset
//  i_start        in   1       start pulse; sampled only in IDLE
//  i_mode         in   1       0: fetch matrices 0..i_matrix_num-1; 1: fetch matrix i_matrix_num only
//  i_matrix_num   in   NUM_W   matrix count (mode 0) or matrix index (mode 1); latched on start
//  o_busy         out  1       high from cycle after accepted start until DONE
//  o_done         out  1       one-cycle pulse in DONE state
//  o_err          out  1       sticky: dout_vld seen with zero outstanding; cleared on accepted start
//  o_mem_rreq     out  1       read request
//  o_mem_addr     out  ADDR_W  read address, valid while o_mem_rreq
//  i_mem_rrdy     in   1       memory accepts request when o_mem_rreq && i_mem_rrdy
//  i_mem_dout     in   DW      read data, in request order
//  i_mem_dout_vld in   1       read data valid; cannot be back-pressured
//  o_row_vld      out  1       row available downstream
//  i_row_rdy      in   1       downstream accepts row when o_row_vld && i_row_rdy
//  o_row_data     out  DW      row data (FIFO head)
//  o_row_idx      out  $clog2(ROWS)  row index 0..MAT_DIM within matrix
//  o_row_mat      out  NUM_W   matrix index of row
//  o_row_last     out  1       row is b vector (o_row_idx==MAT_DIM)
// BEHAVIOUR
//  Reset: state IDLE; all outputs 0; counters, FIFO pointers, outstanding count 0.
//  FSM IDLE->FETCH on i_start (mode 0 with count 0: IDLE->DONE). FETCH->DRAIN when last request
//   accepted. DRAIN->DONE when outstanding==0 and FIFO empty. DONE->IDLE unconditionally (1 cycle).
//  i_start outside IDLE ignored; i_mode/i_matrix_num changes after start ignored.
//  Address = mat*ROWS + row, truncated to ADDR_W (wraps mod 2^ADDR_W); row 0..MAT_DIM, then mat+1.
//  Issue rule: o_mem_rreq=1 in FETCH only if outstanding + fifo_count < FIFO_DEPTH (credit);
//   address/rreq held stable until accepted; no request in other states.
//  First request: o_mem_rreq high cycle after i_start (T+1) if credit available.
//  outstanding +1 on accept, -1 on dout_vld, both same cycle -> unchanged.
//  dout_vld with outstanding==0: data dropped, o_err set; else row pushed with tag of oldest request.
//  Row visible on o_row_vld the cycle after dout_vld (registered FIFO). Simultaneous push/pop when full
//   cannot occur (credit guarantees space); push/pop same cycle keeps count.
//  o_row_* stable while o_row_vld && !i_row_rdy.
//  Async reset mid-operation: immediate return to reset values; pending memory responses after reset
//   are treated as spurious (set o_err).
// TESTING
//  Mode 0, count 2, rrdy=1, 2-cycle read latency, row_rdy=1 -> addrs 0..33, 34 rows, tags (0,0)..(1,16), one done pulse.
//  Mode 1, index 3 -> exactly 17 requests, addrs 51..67, o_row_mat=3, o_row_last only on idx 16.
//  row_rdy=0 throughout -> at most 4 requests issued, rreq held low, FIFO holds 4 rows; release -> completes in order.
//  Random rrdy/row_rdy stalls + variable latency 1..6 -> data order matches reference model, no loss, no overflow.
//  Mode 0 count 0 -> no rreq, o_done 1 cycle after start; dout_vld while idle -> o_err=1, cleared by next start.
//  Reset asserted mid-FETCH -> all outputs 0 next edge; fresh start fetches from addr 0 correctly.

Source files
------------

// File: rtl/gsim_mtx_fetch_if.sv
// Matrix fetch bus: memory read port plus tagged row stream.
// master = fetch engine, slave = memory + datapath side.
interface gsim_mtx_fetch_if #(
  parameter int DW = 256,
  parameter int AW = 10,
  parameter int NW = 5,
  parameter int RW = 5
);
  logic          mem_rreq;
  logic [AW-1:0] mem_addr;
  logic          mem_rrdy;
  logic [DW-1:0] mem_dout;
  logic          mem_dout_vld;
  logic          row_vld;
  logic          row_rdy;
  logic [DW-1:0] row_data;
  logic [RW-1:0] row_idx;
  logic [NW-1:0] row_mat;
  logic          row_last;

  modport master (
    output mem_rreq, mem_addr,
    input  mem_rrdy, mem_dout, mem_dout_vld,
    output row_vld,
    input  row_rdy,
    output row_data, row_idx, row_mat, row_last
  );

  modport slave (
    input  mem_rreq, mem_addr,
    output mem_rrdy, mem_dout, mem_dout_vld,
    input  row_vld,
    output row_rdy,
    input  row_data, row_idx, row_mat, row_last
  );
endinterface

// File: rtl/gsim_mtx_fetch.sv
// Gauss-Seidel matrix fetch engine: issues credit-limited row
// reads, buffers returned rows and streams them tagged downstream.
module gsim_mtx_fetch #(
  parameter int MAT_DIM    = 16,
  parameter int ELEM_W     = 16,
  parameter int ADDR_W     = 10,
  parameter int NUM_W      = 5,
  parameter int FIFO_DEPTH = 4
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic             i_mode,
  input  logic [NUM_W-1:0] i_matrix_num,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_err,
  gsim_mtx_fetch_if.master bus
);
  localparam int ROWS = MAT_DIM + 1;
  localparam int DW   = MAT_DIM * ELEM_W;
  localparam int RW   = $clog2(ROWS);
  localparam int PW   = $clog2(FIFO_DEPTH);
  localparam int CW   = PW + 1;

  typedef enum logic [1:0] {
    S_IDLE, S_FETCH, S_DRAIN, S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [NUM_W-1:0] mat_q, mat_d;
  logic [RW-1:0]    row_q, row_d;
  logic [NUM_W-1:0] end_q, end_d;
  logic [NUM_W-1:0] rmat_q, rmat_d;
  logic [RW-1:0]    rrow_q, rrow_d;
  logic [CW-1:0]    out_q, out_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [PW-1:0]    wp_q, wp_d;
  logic [PW-1:0]    rp_q, rp_d;
  logic             err_q, err_d;

  logic [DW-1:0]    dat_q [FIFO_DEPTH];
  logic [RW-1:0]    tidx_q [FIFO_DEPTH];
  logic [NUM_W-1:0] tmat_q [FIFO_DEPTH];

  logic          credit;
  logic          rreq;
  logic          acc;
  logic          push;
  logic          pop;
  logic          last_req;
  logic [CW:0]   used;
  logic [ADDR_W-1:0] addr;

  assign used   = {1'b0, out_q} + {1'b0, cnt_q};
  assign credit = used < (CW+1)'(FIFO_DEPTH);
  assign rreq   = (state_q == S_FETCH) && credit;
  assign acc    = rreq && bus.mem_rrdy;
  assign push   = bus.mem_dout_vld && (out_q != '0);
  assign pop    = (cnt_q != '0) && bus.row_rdy;
  assign last_req = (row_q == RW'(MAT_DIM)) && (mat_q == end_q);
  assign addr   = ADDR_W'(mat_q) * ADDR_W'(ROWS) + ADDR_W'(row_q);

  assign bus.mem_rreq = rreq;
  assign bus.mem_addr = rreq ? addr : '0;
  assign bus.row_vld  = cnt_q != '0;
  assign bus.row_data = bus.row_vld ? dat_q[rp_q] : '0;
  assign bus.row_idx  = bus.row_vld ? tidx_q[rp_q] : '0;
  assign bus.row_mat  = bus.row_vld ? tmat_q[rp_q] : '0;
  assign bus.row_last = bus.row_vld && (tidx_q[rp_q] == RW'(MAT_DIM));
  assign o_busy = (state_q == S_FETCH) || (state_q == S_DRAIN);
  assign o_done = state_q == S_DONE;
  assign o_err  = err_q;

  // Next state, request/response counters and credit bookkeeping
  always_comb begin
    state_d = state_q;
    mat_d   = mat_q;
    row_d   = row_q;
    end_d   = end_q;
    rmat_d  = rmat_q;
    rrow_d  = rrow_q;
    out_d   = out_q;
    cnt_d   = cnt_q;
    wp_d    = wp_q;
    rp_d    = rp_q;
    err_d   = err_q;

    unique case (state_q)
      S_IDLE: begin
        if (i_start) begin
          err_d  = 1'b0;
          row_d  = '0;
          rrow_d = '0;
          if (i_mode) begin
            mat_d   = i_matrix_num;
            end_d   = i_matrix_num;
            rmat_d  = i_matrix_num;
            state_d = S_FETCH;
          end else begin
            mat_d   = '0;
            end_d   = i_matrix_num - 1'b1;
            rmat_d  = '0;
            state_d = (i_matrix_num == '0) ? S_DONE : S_FETCH;
          end
        end
      end
      S_FETCH: begin
        if (acc) begin
          if (row_q == RW'(MAT_DIM)) begin
            row_d = '0;
            mat_d = mat_q + 1'b1;
          end else begin
            row_d = row_q + 1'b1;
          end
          if (last_req) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (out_q == '0 && cnt_q == '0) state_d = S_DONE;
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (bus.mem_dout_vld && out_q == '0) err_d = 1'b1;

    unique case ({acc, push})
      2'b10:   out_d = out_q + 1'b1;
      2'b01:   out_d = out_q - 1'b1;
      default: out_d = out_q;
    endcase

    unique case ({push, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase

    if (push) begin
      wp_d = wp_q + 1'b1;
      if (rrow_q == RW'(MAT_DIM)) begin
        rrow_d = '0;
        rmat_d = rmat_q + 1'b1;
      end else begin
        rrow_d = rrow_q + 1'b1;
      end
    end
    if (pop) rp_d = rp_q + 1'b1;
  end

  // Control state registers
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= S_IDLE;
      mat_q   <= '0;
      row_q   <= '0;
      end_q   <= '0;
      rmat_q  <= '0;
      rrow_q  <= '0;
      out_q   <= '0;
      cnt_q   <= '0;
      wp_q    <= '0;
      rp_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      mat_q   <= mat_d;
      row_q   <= row_d;
      end_q   <= end_d;
      rmat_q  <= rmat_d;
      rrow_q  <= rrow_d;
      out_q   <= out_d;
      cnt_q   <= cnt_d;
      wp_q    <= wp_d;
      rp_q    <= rp_d;
      err_q   <= err_d;
    end
  end

  // Row buffer storage; occupancy is tracked by cnt_q
  always_ff @(posedge i_clk) begin
    if (push) begin
      dat_q[wp_q]  <= bus.mem_dout;
      tidx_q[wp_q] <= rrow_q;
      tmat_q[wp_q] <= rmat_q;
    end
  end
endmodule

// File: tb/tb_gsim_mtx_fetch.sv
// Directed/table-driven bench for gsim_mtx_fetch with an
// in-order variable-latency memory model and row scoreboard.
module tb_gsim_mtx_fetch;
  localparam int DW   = 256;
  localparam int AW   = 10;
  localparam int NW   = 5;
  localparam int RW   = 5;
  localparam int DEP  = 4;
  localparam int ROWS = 17;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start;
  logic          mode;
  logic [NW-1:0] num;
  logic          busy;
  logic          done;
  logic          err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  gsim_mtx_fetch_if #(.DW(DW), .AW(AW), .NW(NW), .RW(RW)) bus ();

  gsim_mtx_fetch #(
    .MAT_DIM(16), .ELEM_W(16), .ADDR_W(AW),
    .NUM_W(NW), .FIFO_DEPTH(DEP)
  ) dut (
    .i_clk(clk),
    .i_rst_n(rst_n),
    .i_start(start),
    .i_mode(mode),
    .i_matrix_num(num),
    .o_busy(busy),
    .o_done(done),
    .o_err(err),
    .bus(bus.master)
  );

  typedef struct {
    logic    mode;
    int      num;
    int      lat_min;
    int      lat_max;
    int      rrdy_pct;
    int      rdy_pct;
    bit      spam;
    int      hold;
    int      exp_rows;
    int      exp_first;
    int      exp_last;
  } scen_t;

  task automatic chk(input string name, input logic [DW-1:0] act,
                     input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] md(input int a);
    logic [DW-1:0] r;
    for (int i = 0; i < 16; i++)
      r[i*16 +: 16] = 16'(a * 31 + i * 7 + 16'h5A00);
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_scen(input scen_t s);
    int em[$];
    int er[$];
    int pa[$];
    int pd[$];
    int acc_n = 0, rsp_n = 0, pop_n = 0;
    int done_n = 0, post = 0, last_a = -1, k, a;
    logic stall = 1'b0;
    logic [DW-1:0] sv_d;
    logic [RW-1:0] sv_i;
    logic [NW-1:0] sv_m;
    if (s.mode) begin
      for (int r = 0; r < ROWS; r++) begin
        em.push_back(s.num); er.push_back(r);
      end
    end else begin
      for (int m = 0; m < s.num; m++)
        for (int r = 0; r < ROWS; r++) begin
          em.push_back(m); er.push_back(r);
        end
    end
    start = 1'b1; mode = s.mode; num = NW'(s.num);
    tick();
    start = 1'b0;
    chk("busy_after_start", busy, 1);
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (s.spam && done_n == 0) begin
        start = (cyc % 3) == 0;
        mode  = ~s.mode;
        num   = NW'($urandom_range(31));
      end else begin
        start = 1'b0;
      end
      if (s.hold > 0 && cyc == s.hold) begin
        chk("credit_reqs", acc_n, DEP);
        chk("credit_rreq", bus.mem_rreq, 0);
        chk("credit_fifo", rsp_n - pop_n, DEP);
      end
      if (bus.mem_rreq)
        chk("credit_limit", (acc_n - pop_n) < DEP, 1);
      bus.mem_rrdy = (s.hold > 0) ? 1'b1
                   : ($urandom_range(99) < s.rrdy_pct);
      if (bus.mem_rreq && bus.mem_rrdy) begin
        if (acc_n >= em.size()) begin
          chk("extra_req", acc_n, em.size());
        end else begin
          a = (em[acc_n] * ROWS + er[acc_n]) % (1 << AW);
          chk("req_addr", bus.mem_addr, a);
          if (acc_n == 0) chk("first_addr", a, s.exp_first);
          last_a = a;
          pa.push_back(a);
          pd.push_back(cyc + $urandom_range(s.lat_max, s.lat_min));
        end
        acc_n++;
      end
      bus.row_rdy = (cyc < s.hold) ? 1'b0
                  : ($urandom_range(99) < s.rdy_pct);
      if (stall)
        chk("row_hold", {bus.row_vld, bus.row_data, bus.row_idx, bus.row_mat},
            {1'b1, sv_d, sv_i, sv_m});
      if (bus.row_vld && bus.row_rdy) begin
        k = pop_n;
        if (k >= em.size()) begin
          chk("extra_row", k, em.size());
        end else begin
          a = (em[k] * ROWS + er[k]) % (1 << AW);
          chk("row_data", bus.row_data, md(a));
          chk("row_idx", bus.row_idx, er[k]);
          chk("row_mat", bus.row_mat, em[k]);
          chk("row_last", bus.row_last, er[k] == 16);
        end
        pop_n++;
      end
      stall = bus.row_vld && !bus.row_rdy;
      sv_d = bus.row_data; sv_i = bus.row_idx; sv_m = bus.row_mat;
      if (pa.size() > 0 && pd[0] <= cyc) begin
        bus.mem_dout_vld = 1'b1;
        bus.mem_dout = md(pa.pop_front());
        void'(pd.pop_front());
        rsp_n++;
      end else begin
        bus.mem_dout_vld = 1'b0;
        bus.mem_dout = '0;
      end
      if (done) begin
        done_n++;
        chk("busy_at_done", busy, 0);
      end
      if (done_n > 0) post++;
      if (post > 3) break;
      tick();
    end
    start = 1'b0; mode = s.mode; num = NW'(s.num);
    bus.mem_rrdy = 1'b0; bus.mem_dout_vld = 1'b0; bus.row_rdy = 1'b0;
    chk("done_pulses", done_n, 1);
    chk("rows", pop_n, s.exp_rows);
    chk("reqs", acc_n, s.exp_rows);
    chk("last_addr", last_a, s.exp_last);
    chk("err_clean", err, 0);
    tick();
  endtask

  scen_t tbl[5];

  initial begin
    tbl[0] = '{1'b0, 2,  2, 2, 100, 100, 1'b0, 0,  34, 0,   33};
    tbl[1] = '{1'b1, 3,  2, 2, 100, 100, 1'b0, 0,  17, 51,  67};
    tbl[2] = '{1'b0, 3,  1, 6, 70,  60,  1'b1, 0,  51, 0,   50};
    tbl[3] = '{1'b1, 31, 1, 6, 50,  50,  1'b0, 0,  17, 527, 543};
    tbl[4] = '{1'b0, 1,  1, 1, 100, 100, 1'b0, 30, 17, 0,   16};

    start = 1'b0; mode = 1'b0; num = '0;
    bus.mem_rrdy = 1'b0; bus.mem_dout = '0;
    bus.mem_dout_vld = 1'b0; bus.row_rdy = 1'b0;
    #12;
    chk("rst_busy", busy, 0);
    chk("rst_outs", {done, err, bus.mem_rreq, bus.mem_addr, bus.row_vld,
                     bus.row_last, bus.row_idx, bus.row_mat}, 0);
    chk("rst_data", bus.row_data, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 5; i++) run_scen(tbl[i]);

    // mode 0 with count 0: straight to DONE, no requests
    start = 1'b1; mode = 1'b0; num = '0;
    tick();
    start = 1'b0;
    chk("cnt0_done", done, 1);
    chk("cnt0_busy", busy, 0);
    chk("cnt0_rreq", bus.mem_rreq, 0);
    tick();
    chk("cnt0_done_off", done, 0);
    chk("cnt0_rreq2", bus.mem_rreq, 0);

    // spurious response while idle sets sticky error
    bus.mem_dout_vld = 1'b1; bus.mem_dout = md(5);
    tick();
    bus.mem_dout_vld = 1'b0;
    chk("spur_err", err, 1);
    tick();
    chk("spur_sticky", err, 1);
    start = 1'b1; mode = 1'b0; num = '0;
    tick();
    start = 1'b0;
    chk("spur_clr", err, 0);
    tick();

    // reset mid-fetch
    start = 1'b1; mode = 1'b0; num = 5'd2;
    bus.mem_rrdy = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick();
    chk("pre_rst_rreq", bus.mem_rreq, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_outs", {busy, done, err, bus.mem_rreq, bus.mem_addr,
                         bus.row_vld}, 0);
    bus.mem_rrdy = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    bus.mem_dout_vld = 1'b1; bus.mem_dout = md(1);
    tick();
    bus.mem_dout_vld = 1'b0;
    chk("post_rst_spur", err, 1);
    run_scen(tbl[4]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
